// File: rtl/regfile_dumper.sv
// Walks the register file from FIRST_REG to NUM_REGS-1 and streams (index, data) words over valid/ready.
// Optional XOR checksum of dumped words when REGDUMP_CHECKSUM_EN is defined.
module regfile_dumper #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LP_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(NUM_REGS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic [ADDR_W-1:0]   r_index;
  logic [DATA_W-1:0]   r_data;
  logic                w_capture;
  logic                w_accept;
  logic                w_hs;

  assign w_hs = r_valid & dump_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_idx_nxt   = LP_FIRST;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        w_capture   = 1'b1;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          if (r_idx == LP_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_ADDR;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      if (w_capture) begin
        r_index <= r_idx;
        r_data  <= rd_data;
      end
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  // Held after done so the consumer can read it until the next dump begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum ^ r_data;
    end
  end

  assign checksum = r_csum;
`endif

  assign rd_addr    = r_idx;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign dump_valid = r_valid;
  assign dump_index = r_index;
  assign dump_data  = r_data;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: directed steps with random data/ready against a queue-based reference.
module tb_regfile_dumper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        dump_valid, dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;

  logic        s_start;
  logic        s_busy, s_done;
  logic [4:0]  s_rd_addr;
  logic [31:0] s_rd_data;
  logic        s_valid;
  logic [4:0]  s_index;
  logic [31:0] s_data;

  logic [31:0] regs [32];
  logic [31:0] snap [32];

`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] checksum, s_checksum;
`endif

  assign rd_data   = regs[rd_addr];
  assign s_rd_data = regs[s_rd_addr];

  always #5 clk = ~clk;

  regfile_dumper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data)
`ifdef REGDUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  regfile_dumper #(.NUM_REGS(4), .FIRST_REG(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .dump_valid(s_valid), .dump_ready(1'b1),
    .dump_index(s_index), .dump_data(s_data)
`ifdef REGDUMP_CHECKSUM_EN
    , .checksum(s_checksum)
`endif
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          s_done_cnt = 0;
  int          exp_q [$];
  int          exp_q2 [$];
  logic [31:0] csum_model = '0;
  logic [31:0] csum_at_done = '0;
  logic        stall_prev = 1'b0;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe mid-cycle, then advance one edge; inputs set by the caller apply at the next edge.
  task automatic step();
    int w;
    @(negedge clk);
    if (stall_prev) begin
      check("hold_valid", 64'(dump_valid), 64'd1);
      check("hold_index", 64'(dump_index), 64'(prev_idx));
      check("hold_data", 64'(dump_data), 64'(prev_data));
    end
    stall_prev = dump_valid && !dump_ready && rst_n;
    prev_idx   = dump_index;
    prev_data  = dump_data;
    if (dump_valid && dump_ready && rst_n) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 64'(dump_index), 64'hFFFF);
      end else begin
        w = exp_q.pop_front();
        check("word_index", 64'(dump_index), 64'(w));
        check("word_data", 64'(dump_data), 64'(snap[w]));
        csum_model = csum_model ^ snap[w];
      end
    end
    if (done && rst_n) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef REGDUMP_CHECKSUM_EN
      csum_at_done = checksum;
      check("checksum", 64'(checksum), 64'(csum_model));
`endif
    end
    if (s_valid && rst_n) begin
      if (exp_q2.size() == 0) begin
        check("small_extra_word", 64'(s_index), 64'hFFFF);
      end else begin
        w = exp_q2.pop_front();
        check("small_index", 64'(s_index), 64'(w));
        check("small_data", 64'(s_data), 64'(snap[w]));
      end
    end
    if (s_done && rst_n) s_done_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input int first, input int last);
    for (int i = 0; i < 32; i++) snap[i] = regs[i];
    exp_q.delete();
    for (int i = first; i <= last; i++) exp_q.push_back(i);
    csum_model = '0;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    logic seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (done_cnt != d0) seen = 1'b1;
    end
    check("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic wait_word(input int k, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (dump_valid && dump_index == 5'(k)) seen = 1'b1;
      else step();
    end
    check("word_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    int d0;
    rst_n      = 1'b0;
    start      = 1'b0;
    s_start    = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(dump_valid), 64'd0);
    check("rst_index", 64'(dump_index), 64'd0);
    check("rst_data", 64'(dump_data), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    step();

    // Reset while word 7 is pending aborts without a done pulse.
    do_start(0, 31);
    wait_word(7, 40);
    rst_n = 1'b0;
    d0 = done_cnt;
    step();
    rst_n = 1'b1;
    check("abort_valid", 64'(dump_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (4) step();
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    check("abort_idle_valid", 64'(dump_valid), 64'd0);

    // Full dump of reg[i]=i with ready high; latency and done timing.
    do_start(0, 31);
    check("lat_busy", 64'(busy), 64'd1);
    check("lat_valid_e0", 64'(dump_valid), 64'd0);
    check("lat_rd_addr", 64'(rd_addr), 64'd0);
    step();
    check("lat_valid_e1", 64'(dump_valid), 64'd1);
    check("lat_index_e1", 64'(dump_index), 64'd0);
    d0 = done_cnt;
    wait_done(200);
    check("done_cycle", 64'(done_cyc), 64'd65);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("all_words", 64'(exp_q.size()), 64'd0);
    check("busy_in_done", 64'(busy), 64'd0);
    step();
    check("idle_done_low", 64'(done), 64'd0);

    // Write before start shows up in the dump and the checksum.
    regs[5] = 32'hDEADBEEF;
    do_start(0, 31);
    wait_done(200);
    check("write_all_words", 64'(exp_q.size()), 64'd0);
`ifdef REGDUMP_CHECKSUM_EN
    check("csum_value", 64'(csum_at_done), 64'hDEADBEEA);
    repeat (3) step();
    check("csum_held", 64'(checksum), 64'hDEADBEEA);
`endif

    // Backpressure on word 3 for five cycles; random register contents.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_start(0, 31);
    wait_word(3, 20);
    dump_ready = 1'b0;
    repeat (5) begin
      step();
      check("bp_index", 64'(dump_index), 64'd3);
      check("bp_data", 64'(dump_data), 64'(snap[3]));
    end
    dump_ready = 1'b1;
    wait_done(200);
    check("bp_all_words", 64'(exp_q.size()), 64'd0);

    // Random ready throughout a dump.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_start(0, 31);
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      dump_ready = 1'($urandom_range(0, 1));
      step();
    end
    dump_ready = 1'b1;
    check("rand_done", 64'(done_cnt - d0), 64'd1);
    check("rand_all_words", 64'(exp_q.size()), 64'd0);

    // Start while busy is ignored.
    do_start(0, 31);
    wait_word(10, 40);
    start = 1'b1;
    step();
    start = 1'b0;
    d0 = done_cnt;
    wait_done(200);
    check("restart_all_words", 64'(exp_q.size()), 64'd0);
    repeat (6) step();
    check("restart_single_done", 64'(done_cnt - d0), 64'd1);
    check("restart_no_new_dump", 64'(busy), 64'd0);

    // FIRST_REG=1, NUM_REGS=4 instance.
    for (int i = 0; i < 32; i++) snap[i] = regs[i];
    exp_q2.delete();
    for (int i = 1; i <= 3; i++) exp_q2.push_back(i);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    d0 = s_done_cnt;
    for (int i = 0; i < 40 && s_done_cnt == d0; i++) step();
    check("small_done", 64'(s_done_cnt - d0), 64'd1);
    check("small_all_words", 64'(exp_q2.size()), 64'd0);
    repeat (3) step();
    check("small_idle", 64'(s_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
